// File: rtl/sky_field.sv
// Falling-cell sky: NUM_COLS x NUM_ROWS occupancy grid with LFSR spawning and a pixel rasteriser.
// Optional build macro SKY_FIELD_SKIP_EMPTY_EN: empty cells take one non-plotting cycle each.
module sky_field #(
   parameter int          NUM_COLS  = 4,
   parameter int          NUM_ROWS  = 14,
   parameter int          CELL_SIZE = 4,
   parameter int          X_ORIGIN  = 0,
   parameter int          Y_ORIGIN  = 0,
   parameter logic [2:0]  FG_COLOR  = 3'b111,
   parameter logic [2:0]  BG_COLOR  = 3'b000,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                update,
   input  logic                draw_start,
   output logic                plot,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [2:0]          color,
   output logic                busy,
   output logic                draw_done,
   output logic [NUM_COLS-1:0] bottom_row
);

   // state | meaning
   // IDLE  | grid live, updates applied immediately, waiting for draw_start
   // DRAW  | one pixel (or skipped cell) per cycle, grid frozen, updates deferred
   // DONE  | draw_done pulse; deferred update applied on the exit edge
   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   localparam int CS2 = CELL_SIZE * CELL_SIZE;
   localparam int CW  = $clog2(NUM_COLS);
   localparam int RW  = $clog2(NUM_ROWS);
   localparam int PW  = (CS2 > 1) ? $clog2(CS2) : 1;

   state_t                              state, state_nxt;
   logic [CW-1:0]                       col_q, col_n;
   logic [RW-1:0]                       row_q, row_n;
   logic [PW-1:0]                       pix_q, pix_n;
   logic [NUM_COLS-1:0][NUM_ROWS-1:0]   grid, grid_nxt;
   logic [7:0]                          lfsr, lfsr_nxt, spawn_idx;
   logic                                pending, pending_nxt;
   logic                                apply_upd;
   logic                                cell_last;
   logic                                nxt_occ;
   logic                                plot_n;
   logic [7:0]                          x_n;
   logic [6:0]                          y_n;
   logic [2:0]                          color_n;

   assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign spawn_idx = lfsr_nxt & 8'(2 * NUM_COLS - 1);

   // A deferred update lands on the DONE->IDLE edge; back-to-back requests collapse to one scroll.
   assign apply_upd = ((state == S_IDLE) && update) ||
                      ((state == S_DONE) && (pending || update));

   always_comb begin
      pending_nxt = 1'b0;
      if (state == S_DRAW)
         pending_nxt = pending | update;
   end

   always_comb begin
      grid_nxt = grid;
      if (apply_upd) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            grid_nxt[c] = {grid[c][NUM_ROWS-2:0], 1'b0};
            if (spawn_idx == 8'(c))
               grid_nxt[c][0] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_COLS; c++)
         bottom_row[c] = grid[c][NUM_ROWS-1];
   end

`ifdef SKY_FIELD_SKIP_EMPTY_EN
   logic cell_occ;
   assign cell_occ  = grid[col_q][row_q];
   assign cell_last = (pix_q == PW'(CS2 - 1)) || !cell_occ;
`else
   assign cell_last = (pix_q == PW'(CS2 - 1));
`endif

   always_comb begin
      state_nxt = state;
      col_n     = col_q;
      row_n     = row_q;
      pix_n     = pix_q;
      unique case (state)
         S_IDLE: begin
            if (draw_start) begin
               state_nxt = S_DRAW;
               col_n     = '0;
               row_n     = '0;
               pix_n     = '0;
            end
         end
         S_DRAW: begin
            if (cell_last) begin
               pix_n = '0;
               if (row_q == RW'(NUM_ROWS - 1)) begin
                  row_n = '0;
                  if (col_q == CW'(NUM_COLS - 1))
                     state_nxt = S_DONE;
                  else
                     col_n = col_q + CW'(1);
               end else begin
                  row_n = row_q + RW'(1);
               end
            end else begin
               pix_n = pix_q + PW'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pixel outputs are precomputed from the next counters so they register alongside the state.
   always_comb begin
      nxt_occ = grid_nxt[col_n][row_n];
      x_n     = 8'(X_ORIGIN + int'(col_n) * CELL_SIZE + int'(pix_n) % CELL_SIZE);
      y_n     = 7'(Y_ORIGIN + int'(row_n) * CELL_SIZE + int'(pix_n) / CELL_SIZE);
      color_n = nxt_occ ? FG_COLOR : BG_COLOR;
`ifdef SKY_FIELD_SKIP_EMPTY_EN
      plot_n  = (state_nxt == S_DRAW) && nxt_occ;
`else
      plot_n  = (state_nxt == S_DRAW);
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         pix_q     <= '0;
         grid      <= '0;
         lfsr      <= LFSR_SEED;
         pending   <= 1'b0;
         plot      <= 1'b0;
         x         <= '0;
         y         <= '0;
         color     <= '0;
         busy      <= 1'b0;
         draw_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         col_q     <= col_n;
         row_q     <= row_n;
         pix_q     <= pix_n;
         grid      <= grid_nxt;
         pending   <= pending_nxt;
         if (apply_upd)
            lfsr <= lfsr_nxt;
         plot      <= plot_n;
         busy      <= (state_nxt != S_IDLE);
         draw_done <= (state_nxt == S_DONE);
         if (plot_n) begin
            x     <= x_n;
            y     <= y_n;
            color <= color_n;
         end
      end
   end

endmodule

// File: tb/tb_sky_field.sv
// Bench for sky_field: grid/LFSR reference model, full-draw pixel checking, deferred updates, reset abort.
module tb_sky_field;

   localparam int         NC = 4;
   localparam int         NR = 14;
   localparam int         CS = 4;
   localparam int         XO = 0;
   localparam int         YO = 0;
   localparam logic [2:0] FG = 3'b111;
   localparam logic [2:0] BG = 3'b000;
`ifdef SKY_FIELD_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          update = 1'b0;
   logic          draw_start = 1'b0;
   logic          plot;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    color;
   logic          busy;
   logic          draw_done;
   logic [NC-1:0] bottom_row;

   sky_field #(
      .NUM_COLS(NC), .NUM_ROWS(NR), .CELL_SIZE(CS), .X_ORIGIN(XO), .Y_ORIGIN(YO),
      .FG_COLOR(FG), .BG_COLOR(BG), .LFSR_SEED(8'hA5)
   ) dut (
      .clock(clock), .reset(reset), .update(update), .draw_start(draw_start),
      .plot(plot), .x(x), .y(y), .color(color), .busy(busy),
      .draw_done(draw_done), .bottom_row(bottom_row)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   bit         mg [NC][NR];
   logic [7:0] ml;
   int         ex[$], ey[$], ec[$];
   int         exp_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      ml = 8'hA5;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            mg[c][r] = 1'b0;
   endtask

   task automatic model_update();
      int idx;
      ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
      for (int c = 0; c < NC; c++) begin
         for (int r = NR - 1; r > 0; r--)
            mg[c][r] = mg[c][r-1];
         mg[c][0] = 1'b0;
      end
      idx = int'(ml) % (2 * NC);
      if (idx < NC)
         mg[idx][0] = 1'b1;
   endtask

   function automatic logic [NC-1:0] model_bottom();
      logic [NC-1:0] b;
      for (int c = 0; c < NC; c++)
         b[c] = mg[c][NR-1];
      return b;
   endfunction

   task automatic build_expected();
      int skipped;
      ex.delete(); ey.delete(); ec.delete();
      skipped = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++) begin
            if (!SKIP || mg[c][r]) begin
               for (int p = 0; p < CS * CS; p++) begin
                  ex.push_back((XO + c * CS + p % CS) % 256);
                  ey.push_back((YO + r * CS + p / CS) % 128);
                  ec.push_back(mg[c][r] ? int'(FG) : int'(BG));
               end
            end else begin
               skipped++;
            end
         end
      exp_total = ex.size() + skipped + 1;
   endtask

   task automatic pulse_updates(input int n);
      for (int i = 0; i < n; i++) begin
         update = 1'b1;
         @(negedge clock);
         update = 1'b0;
         model_update();
         chk("bottom_row_after_update", bottom_row, model_bottom());
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
   endtask

   task automatic run_draw(input int upd_at_i, input int n_upd, input bit upd_with_start,
                           input int ignore_at_i, input int reset_at_i);
      int k, plots, mism, done_cnt, done_at, upd_at, ignore_at, reset_at;
      int fx, fy, lx, ly;
      bit aborted;
      logic [NC-1:0] pre_bottom;
      if (upd_with_start) model_update();
      build_expected();
      pre_bottom = model_bottom();
      upd_at = upd_at_i;
      if (n_upd > 0 && upd_at + n_upd > exp_total - 1) upd_at = 1;
      ignore_at = ignore_at_i;
      if (ignore_at >= exp_total) ignore_at = 2;
      reset_at = reset_at_i;
      if (reset_at >= exp_total) reset_at = exp_total / 2;
      draw_start = 1'b1;
      update     = upd_with_start;
      @(negedge clock);
      draw_start = 1'b0;
      update     = 1'b0;
      k = 0; plots = 0; mism = 0; done_cnt = 0; done_at = 0;
      fx = -1; fy = -1; lx = -1; ly = -1;
      aborted = 1'b0;
      while (busy === 1'b1 && k < 5000) begin
         k++;
         if (plot === 1'b1) begin
            if (plots < ex.size()) begin
               if (int'(x) != ex[plots] || int'(y) != ey[plots] || int'(color) != ec[plots])
                  mism++;
            end else begin
               mism++;
            end
            if (plots == 0) begin fx = int'(x); fy = int'(y); end
            lx = int'(x); ly = int'(y);
            plots++;
         end
         if (draw_done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (k == exp_total)
            chk("bottom_row_frozen_in_draw", bottom_row, pre_bottom);
         if (reset_at > 0 && k == reset_at) begin
            reset = 1'b1;
            #1;
            chk("abort_plot", plot, 1'b0);
            chk("abort_busy", busy, 1'b0);
            chk("abort_draw_done", draw_done, 1'b0);
            chk("abort_bottom_row", bottom_row, '0);
            aborted = 1'b1;
            break;
         end
         update     = (n_upd > 0 && k >= upd_at && k < upd_at + n_upd);
         draw_start = (ignore_at > 0 && k == ignore_at);
         @(negedge clock);
      end
      update     = 1'b0;
      draw_start = 1'b0;
      if (aborted) begin
         @(negedge clock);
         chk("abort_no_done_later", draw_done, 1'b0);
         chk("abort_busy_later", busy, 1'b0);
         reset = 1'b0;
         model_reset();
         @(negedge clock);
         return;
      end
      chk("busy_length", k, exp_total);
      chk("plot_count", plots, ex.size());
      chk("pixel_mismatches", mism, 0);
      chk("draw_done_count", done_cnt, 1);
      chk("draw_done_position", done_at, exp_total);
      if (ex.size() > 0) begin
         chk("first_pixel_x", fx, ex[0]);
         chk("first_pixel_y", fy, ey[0]);
         chk("last_pixel_x", lx, ex[ex.size()-1]);
         chk("last_pixel_y", ly, ey[ey.size()-1]);
      end
      if (n_upd > 0) model_update();
      chk("bottom_row_after_draw", bottom_row, model_bottom());
      chk("idle_after_draw", busy, 1'b0);
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("reset_plot", plot, 1'b0);
      chk("reset_x", x, 8'd0);
      chk("reset_y", y, 7'd0);
      chk("reset_color", color, 3'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_draw_done", draw_done, 1'b0);
      chk("reset_bottom_row", bottom_row, '0);
      reset = 1'b0;
      @(negedge clock);

      // empty grid draw, then first spawn lands in column 2
      run_draw(0, 0, 1'b0, 0, 0);
      pulse_updates(1);
      run_draw(0, 0, 1'b0, 0, 0);

      // first spawned cell reaches the bottom after 14 updates, gone after 15
      pulse_updates(13);
      chk("bottom_col2_after_14_updates", bottom_row[2], 1'b1);
      pulse_updates(1);

      // deferred updates, same-cycle update/draw_start, ignored draw_start
      run_draw(100, 1, 1'b0, 0, 0);
      run_draw(50, 3, 1'b0, 0, 0);
      run_draw(0, 0, 1'b1, 0, 0);
      run_draw(0, 0, 1'b0, 200, 0);

      // reset in the middle of a draw, then confirm seed restored
      run_draw(0, 0, 1'b0, 0, 300);
      pulse_updates(1);
      run_draw(0, 0, 1'b0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         int nu, ig;
         pulse_updates($urandom_range(0, 6));
         nu = $urandom_range(0, 3);
         ig = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 800) : 0;
         run_draw(int'($urandom_range(1, 600)), nu, 1'($urandom_range(0, 1)), ig, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sky_field.md
Name: sky_field

Overview:
- Parametrised successor to the four-column meatball sky.
- Holds a NUM_COLS x NUM_ROWS occupancy grid of falling cells.
- On each `update` pulse it scrolls the grid down one row and may spawn a new cell in row 0, chosen by an internal LFSR.
- On `draw_start` it rasterises the whole grid into single-pixel VGA-adapter writes (`plot`/`x`/`y`/`color`) and signals completion. It also exports bottom-row occupancy for collision logic.

Parameters:
- NUM_COLS, 4, column count; power of two, 2..16.
- NUM_ROWS, 14, rows per column, 2..30.
- CELL_SIZE, 4, cell edge in pixels; power of two, 1..8.
- X_ORIGIN, 0, screen x of column 0 left edge.
- Y_ORIGIN, 0, screen y of row 0 top edge.
- FG_COLOR, 3'b111, colour of an occupied cell.
- BG_COLOR, 3'b000, colour of an empty cell.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- update  input  1  one-cycle pulse: scroll grid and spawn.
- draw_start  input  1  one-cycle pulse: begin rasterising.
- plot  output  1  pixel write enable to VGA adapter.
- x  output  8  pixel x.
- y  output  7  pixel y.
- color  output  3  pixel colour.
- busy  output  1  high while a draw is in progress.
- draw_done  output  1  one-cycle pulse at end of draw.
- bottom_row  output  NUM_COLS  occupancy of row NUM_ROWS-1, bit c = column c.

Behaviour:
- Reset:
  - Grid all 0; LFSR = LFSR_SEED.
  - FSM = IDLE; update_pending = 0.
  - plot = 0, x = 0, y = 0, color = 0, busy = 0, draw_done = 0.
  - bottom_row = 0.
  - Reset asserted mid-draw aborts the draw immediately; no draw_done is issued.
- LFSR: on each applied update, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Applied update, one clock edge:
  - Every column shifts down: row r <= row r-1 for r >= 1; row 0 cleared; old row NUM_ROWS-1 is discarded.
  - Spawn: idx = next_lfsr mod (2*NUM_COLS). If idx < NUM_COLS, row 0 of column idx is set; otherwise no spawn.
- Update timing:
  - In IDLE, an update is applied on the edge it is sampled.
  - In DRAW or DONE, an update sets update_pending instead. Multiple pending updates collapse to one.
  - The pending update is applied on the edge that returns the FSM to IDLE, so the grid is frozen throughout a draw.
- FSM states IDLE, DRAW, DONE:
  - IDLE: draw_start=1 -> DRAW with counters col=0, row=0, pix=0; busy goes high next cycle.
  - DRAW, one pixel per cycle:
    - plot = 1; dx = pix mod CELL_SIZE; dy = pix / CELL_SIZE.
    - x = X_ORIGIN + col*CELL_SIZE + dx; y = Y_ORIGIN + row*CELL_SIZE + dy; widths truncate to 8 and 7 bits.
    - color = FG_COLOR if cell occupied, else BG_COLOR.
    - Order is column-major: pix fastest, then row, then col.
    - After the last pixel of (NUM_COLS-1, NUM_ROWS-1) -> DONE.
  - DONE: plot = 0, draw_done = 1 for one cycle, busy = 1 -> IDLE.
- Outputs are registered. Total draw is NUM_COLS*NUM_ROWS*CELL_SIZE^2 plot cycles plus one DONE cycle. With defaults that is 896 + 1; busy spans exactly 897 cycles.
- draw_start while busy is ignored.
- draw_start and update in the same IDLE cycle: the update is applied on that edge, so the draw shows the post-update grid.
- x, y and color hold their last values when plot = 0.
- bottom_row is combinational from the grid; it changes only when an update is applied.

Optional Feature:
- Macro: SKY_FIELD_SKIP_EMPTY_EN.
- Defined:
  - Empty cells are skipped in one cycle each, with plot = 0.
  - Occupied cells plot CELL_SIZE^2 pixels in FG_COLOR.
  - Draw length = (empty cells) + (occupied cells)*CELL_SIZE^2, plus the DONE cycle.
  - The background is assumed cleared by the owner of the framebuffer.
- Undefined: every cell is fully drawn, as described under Behaviour.

Test Plan:
- Reset, then one update -> next_lfsr = 8'h4A, idx = 2: grid row 0 = 4'b0100 (col 2 set), bottom_row = 0.
- Reset, 14 updates, then one more -> bottom_row shows the col-2 cell spawned by the first update before it drops off; the 15th update removes it.
- Reset, draw_start -> busy for 897 cycles, 896 plot pulses all BG_COLOR. First pixel (0,0), last pixel (15,55), then a single draw_done.
- Update pulse at draw pixel 100 with a spawning LFSR state -> no grid change during the draw; change visible on the edge busy falls; three updates during the draw still apply only one scroll.
- Reset asserted at plot cycle 300 -> plot = 0, busy = 0 immediately, no draw_done, grid cleared, LFSR = 8'hA5.
- With SKY_FIELD_SKIP_EMPTY_EN, one occupied cell -> exactly 16 plot pulses in FG_COLOR; busy spans 55 + 16 + 1 = 72 cycles.
